unidad_control: RTL and testbench

Control unit for the Booth-multiplier datapath in the multiplier practice. It sequences the datapath's A register (accumulator), Q register (multiplier), M register (multiplicand), the Q-1 flip-flop and the add/subtract unit. It samples the two Booth decision bits (Q[0], Q-1) and issues one-cycle load, add/subtract and arithmetic-shift commands for N iterations. A start/finish handshake connects it to the surrounding test harness or top level.

---
 rtl/unidad_control_if.sv | 32 +++
 rtl/unidad_control.sv | 104 ++++++++++
 tb/tb_unidad_control.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/unidad_control_if.sv
// Signal bundle between the Booth control unit and its datapath/harness.
//
// Start/finish handshake: the harness raises inicio (level) and the unit
// accepts it only from REPOSO, answering with ocupado=1 for the whole
// operation. When the product is valid fin rises and stays high for as long
// as inicio stays high; the harness drops inicio to acknowledge, and the
// unit returns to REPOSO one cycle later. A new operation needs a fresh
// rise of inicio after that point. Changes of inicio while ocupado=1 have
// no effect.
interface unidad_control_if;
    logic inicio;
    logic q0;
    logic qm1;
    logic carga_ini;
    logic carga_a;
    logic resta;
    logic desplaza;
    logic ocupado;
    logic fin;

    // Harness / datapath side
    modport master (
        output inicio, q0, qm1,
        input  carga_ini, carga_a, resta, desplaza, ocupado, fin
    );

    // Control unit side
    modport slave (
        input  inicio, q0, qm1,
        output carga_ini, carga_a, resta, desplaza, ocupado, fin
    );
endinterface

// File: rtl/unidad_control.sv
// Moore control unit sequencing a Booth multiplier datapath for N iterations.
// All commands are decoded from the state register alone, so they are stable
// for the whole cycle and the datapath acts on the edge that ends it.
module unidad_control #(
    parameter int N = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    unidad_control_if.slave          ctl,
    output logic [2:0]               estado_dbg,
    output logic [$clog2(N+1)-1:0]   cnt_dbg
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_N   = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_REPOSO   = 3'd0,
        S_CARGA    = 3'd1,
        S_EVALUA   = 3'd2,
        S_SUMA     = 3'd3,
        S_RESTA    = 3'd4,
        S_DESPLAZA = 3'd5,
        S_FIN      = 3'd6
    } estado_t;

    estado_t        estado, estado_sig;
    logic [CW-1:0]  cnt;

    assign estado_dbg = estado;
    assign cnt_dbg    = cnt;

    // State register; reset drops to REPOSO without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado <= S_REPOSO;
        else        estado <= estado_sig;
    end

    // Iteration counter: loaded in CARGA, counts down once per shift only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            case (estado)
                S_CARGA:    cnt <= CNT_N;
                S_DESPLAZA: cnt <= cnt - CNT_ONE;
                default:    cnt <= cnt;
            endcase
        end
    end

    // Next-state logic; Booth bits are only looked at in EVALUA.
    always_comb begin
        estado_sig = estado;
        case (estado)
            S_REPOSO:   if (ctl.inicio) estado_sig = S_CARGA;
            S_CARGA:    estado_sig = S_EVALUA;
            S_EVALUA: begin
                case ({ctl.q0, ctl.qm1})
                    2'b10:   estado_sig = S_RESTA;
                    2'b01:   estado_sig = S_SUMA;
                    default: estado_sig = S_DESPLAZA;
                endcase
            end
            S_SUMA:     estado_sig = S_DESPLAZA;
            S_RESTA:    estado_sig = S_DESPLAZA;
            S_DESPLAZA: estado_sig = (cnt == CNT_ONE) ? S_FIN : S_EVALUA;
            S_FIN:      if (!ctl.inicio) estado_sig = S_REPOSO;
            default:    estado_sig = S_REPOSO;
        endcase
    end

    // Output decode from the state register only (Moore).
    always_comb begin
        ctl.carga_ini = 1'b0;
        ctl.carga_a   = 1'b0;
        ctl.resta     = 1'b0;
        ctl.desplaza  = 1'b0;
        ctl.ocupado   = 1'b0;
        ctl.fin       = 1'b0;
        case (estado)
            S_CARGA: begin
                ctl.carga_ini = 1'b1;
                ctl.ocupado   = 1'b1;
            end
            S_EVALUA: ctl.ocupado = 1'b1;
            S_SUMA: begin
                ctl.carga_a = 1'b1;
                ctl.ocupado = 1'b1;
            end
            S_RESTA: begin
                ctl.carga_a = 1'b1;
                ctl.resta   = 1'b1;
                ctl.ocupado = 1'b1;
            end
            S_DESPLAZA: begin
                ctl.desplaza = 1'b1;
                ctl.ocupado  = 1'b1;
            end
            S_FIN:   ctl.fin = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_unidad_control.sv
// Directed bench for unidad_control (N=3). Expected per-cycle outputs are
// written as character strings: each letter names the state the unit must
// be in during that cycle, and the letter maps to a hand-written 6-bit
// pattern {carga_ini, carga_a, resta, desplaza, ocupado, fin}.
module tb_unidad_control;
    logic clk;
    logic reset;
    logic [2:0] estado_dbg;
    logic [1:0] cnt_dbg;
    int n_assert;
    int n_fail;

    unidad_control_if ifc ();

    unidad_control #(.N(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctl        (ifc.slave),
        .estado_dbg (estado_dbg),
        .cnt_dbg    (cnt_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] O_P = 6'b000000; // REPOSO
    localparam logic [5:0] O_C = 6'b100010; // CARGA
    localparam logic [5:0] O_E = 6'b000010; // EVALUA
    localparam logic [5:0] O_S = 6'b010010; // SUMA
    localparam logic [5:0] O_R = 6'b011010; // RESTA
    localparam logic [5:0] O_D = 6'b000110; // DESPLAZA
    localparam logic [5:0] O_F = 6'b000001; // FIN

    logic [5:0] outs;
    assign outs = {ifc.carga_ini, ifc.carga_a, ifc.resta,
                   ifc.desplaza, ifc.ocupado, ifc.fin};

    function automatic logic [5:0] exp_of(input byte c);
        case (c)
            "C":     return O_C;
            "E":     return O_E;
            "S":     return O_S;
            "R":     return O_R;
            "D":     return O_D;
            "F":     return O_F;
            default: return O_P;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [5:0] exp);
        n_assert++;
        assert (outs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scenario: per cycle, step, check, then drive q0/qm1 for that
    // cycle. q chars '0'..'3' give {q0,qm1}; 'x' drives a random value
    // (a cycle where the unit must ignore the Booth bits).
    task automatic run_scn(input string tag, input string exp_s,
                           input string q_s, input bit drop_inicio);
        for (int i = 0; i < exp_s.len(); i++) begin
            tick();
            if (drop_inicio && i == 0) ifc.inicio = 1'b0;
            chk($sformatf("%s_c%0d", tag, i + 1), exp_of(exp_s[i]));
            if (q_s[i] == "x")
                {ifc.q0, ifc.qm1} = 2'($urandom_range(0, 3));
            else
                {ifc.q0, ifc.qm1} = 2'(q_s[i] - "0");
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        ifc.inicio = 1'b1;
        ifc.q0     = 1'b0;
        ifc.qm1    = 1'b0;

        // Reset held with inicio=1: nothing may start.
        #1;
        chk("rst_t0", O_P);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_hold%0d", i), O_P);
        end
        reset = 1'b1;

        // First edge after release loads; inicio stays high through to FIN,
        // and FIN must hold (no commands) while inicio stays high.
        tick();
        chk("rel_carga", O_C);
        run_scn("hs", "EDEDEDFFFFFF", "0x0x0xxxxxxx", 1'b0);

        // Dropping inicio returns to REPOSO; a new rise starts again.
        ifc.inicio = 1'b0;
        tick();
        chk("hs_reposo", O_P);
        ifc.inicio = 1'b1;
        tick();
        chk("hs_recarga", O_C);
        ifc.inicio = 1'b0;
        {ifc.q0, ifc.qm1} = 2'b10;
        tick();
        chk("ar_evalua", O_E);
        tick();
        chk("ar_resta", O_R);

        // Asynchronous reset in the middle of RESTA.
        #3;
        reset = 1'b0;
        #1;
        chk("ar_async", O_P);
        tick();
        chk("ar_held", O_P);
        reset      = 1'b1;
        ifc.inicio = 1'b1;

        // Sequence 10, 11, 01 after the reset.
        run_scn("mix", "CERDEDESDFP", "x2xx3x1xxxx", 1'b1);

        // All 00: shifts only.
        ifc.inicio = 1'b1;
        run_scn("z00", "CEDEDEDFP", "x0x0x0xxx", 1'b1);

        // All 10: subtract every iteration.
        ifc.inicio = 1'b1;
        run_scn("r10", "CERDERDERDFP", "x2xx2xx2xxxx", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
